// File: rtl/reg_dump_reader_if.sv
// Register-dump stream interface: dump control, register-file read port and
// the outgoing word stream with its valid/ready handshake.
interface reg_dump_reader_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int REG_ADD_WIDTH = 5
);
    logic                     START;
    logic                     ABORT;
    logic [REG_ADD_WIDTH-1:0] FIRST_REG;
    logic [REG_ADD_WIDTH-1:0] LAST_REG;
    logic [REG_ADD_WIDTH-1:0] RD_ADDR;
    logic [DATA_WIDTH-1:0]    RD_DATA;
    logic                     OUT_VALID;
    logic                     OUT_READY;
    logic [DATA_WIDTH-1:0]    OUT_DATA;
    logic [REG_ADD_WIDTH-1:0] OUT_INDEX;
    logic                     OUT_LAST;
    logic                     BUSY;
    logic                     DONE;

    // Dump engine side.
    modport slave (
        input  START, ABORT, FIRST_REG, LAST_REG, RD_DATA, OUT_READY,
        output RD_ADDR, OUT_VALID, OUT_DATA, OUT_INDEX, OUT_LAST, BUSY, DONE
    );

    // Controller / register file / sink side.
    modport master (
        output START, ABORT, FIRST_REG, LAST_REG, RD_DATA, OUT_READY,
        input  RD_ADDR, OUT_VALID, OUT_DATA, OUT_INDEX, OUT_LAST, BUSY, DONE
    );
endinterface

// File: rtl/reg_dump_reader.sv
// Streams a contiguous (possibly wrapping) range of register-file words out
// over a valid/ready port, one word per cycle when the sink keeps up.
module reg_dump_reader #(
    parameter int DATA_WIDTH    = 32,
    parameter int REG_ADD_WIDTH = 5,
    parameter int NUM_REGS      = 2**REG_ADD_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    reg_dump_reader_if.slave bus
);
    localparam int                       CNT_WIDTH = $clog2(NUM_REGS + 1);
    localparam logic [CNT_WIDTH-1:0]     CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]     CNT_NUM   = CNT_WIDTH'(NUM_REGS);
    localparam logic [REG_ADD_WIDTH-1:0] ADDR_MAX  = REG_ADD_WIDTH'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        FIN
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;

    logic [REG_ADD_WIDTH-1:0] r_addr;
    logic [CNT_WIDTH-1:0]     r_remain;
    logic [DATA_WIDTH-1:0]    r_out_data;
    logic [REG_ADD_WIDTH-1:0] r_out_index;
    logic                     r_out_valid;
    logic                     r_out_last;

    logic                     w_start;
    logic                     w_load;
    logic                     w_accept;
    logic                     w_abort;
    logic [CNT_WIDTH-1:0]     w_word_count;
    logic [REG_ADD_WIDTH-1:0] w_addr_next;

    // Next read address wraps from the top register back to address 0.
    assign w_addr_next = (r_addr == ADDR_MAX) ? '0 : r_addr + 1'b1;

    // Word count of the requested range; a reversed range wraps through address 0.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned (which would infer a latch).
        w_word_count = '0;
        if (bus.LAST_REG >= bus.FIRST_REG) begin
            w_word_count = CNT_WIDTH'(bus.LAST_REG) - CNT_WIDTH'(bus.FIRST_REG) + CNT_ONE;
        end else begin
            w_word_count = CNT_NUM - CNT_WIDTH'(bus.FIRST_REG) + CNT_WIDTH'(bus.LAST_REG) + CNT_ONE;
        end
    end

    // Next-state decode plus the strobes that drive the datapath.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_load       = 1'b0;
        w_accept     = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                // Abort alongside start cancels the request before it begins.
                if (bus.START && !bus.ABORT) begin
                    w_start      = 1'b1;
                    w_state_next = STREAM;
                end
            end
            STREAM: begin
                // Abort takes priority over a load in the same cycle.
                if (bus.ABORT) begin
                    w_abort      = 1'b1;
                    w_state_next = IDLE;
                end else if (!r_out_valid || bus.OUT_READY) begin
                    w_load = 1'b1;
                    if (r_remain == CNT_ONE) begin
                        w_state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (bus.ABORT) begin
                    w_abort      = 1'b1;
                    w_state_next = IDLE;
                end else if (r_out_valid && bus.OUT_READY) begin
                    w_accept     = 1'b1;
                    w_state_next = FIN;
                end
            end
            FIN: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state <= w_state_next;
        end
    end

    // Address/remaining-count counters and the registered output word.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_addr      <= '0;
            r_remain    <= '0;
            r_out_data  <= '0;
            r_out_index <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_start) begin
                r_addr   <= bus.FIRST_REG;
                r_remain <= w_word_count;
            end
            // Data is captured from the read port in the cycle of the load itself.
            if (w_load) begin
                r_out_data  <= bus.RD_DATA;
                r_out_index <= r_addr;
                r_out_valid <= 1'b1;
                r_out_last  <= (r_remain == CNT_ONE);
                r_addr      <= w_addr_next;
                r_remain    <= r_remain - CNT_ONE;
            end
            if (w_accept || w_abort) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign bus.RD_ADDR   = r_addr;
    assign bus.OUT_VALID = r_out_valid;
    assign bus.OUT_DATA  = r_out_data;
    assign bus.OUT_INDEX = r_out_index;
    assign bus.OUT_LAST  = r_out_last;
    assign bus.BUSY      = (r_state == STREAM) || (r_state == DRAIN);
    assign bus.DONE      = (r_state == FIN);
endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader: directed dumps plus randomized
// dumps, checked every cycle against a transaction-level model of the dump.
module tb_reg_dump_reader;
    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NUM = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    reg_dump_reader_if #(.DATA_WIDTH(DW), .REG_ADD_WIDTH(AW)) bus ();

    reg_dump_reader #(
        .DATA_WIDTH   (DW),
        .REG_ADD_WIDTH(AW),
        .NUM_REGS     (NUM)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    // Register file with a combinational read port.
    logic [DW-1:0] regs [NUM];
    assign bus.RD_DATA = regs[bus.RD_ADDR];

    typedef struct {
        int          idx;
        logic [DW-1:0] data;
        logic        last;
    } word_t;

    word_t exp_q [$];
    word_t acc_q [$];

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    bit just_started  = 1'b0;
    bit exp_done_next = 1'b0;
    bit abort_pending = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected words of one dump: every address from first to last inclusive, wrapping.
    function automatic void push_dump(input int first, input int last);
        int    n = ((last - first + NUM) % NUM) + 1;
        word_t w;
        for (int k = 0; k < n; k++) begin
            w.idx  = (first + k) % NUM;
            w.data = regs[w.idx];
            w.last = (k == n - 1);
            exp_q.push_back(w);
        end
    endfunction

    // Per-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        word_t w;
        word_t a;
        if (!rst) begin
            exp_q.delete();
            just_started  = 1'b0;
            exp_done_next = 1'b0;
            abort_pending = 1'b0;
        end else begin
            check("done", bus.DONE, exp_done_next);
            exp_done_next = 1'b0;
            if (bus.DONE) done_cnt++;
            check("busy", bus.BUSY, (exp_q.size() > 0) && !just_started);
            just_started = 1'b0;
            if (abort_pending) begin
                check("abort_valid", bus.OUT_VALID, 1'b0);
                abort_pending = 1'b0;
            end
            if (bus.ABORT) begin
                exp_q.delete();
                abort_pending = 1'b1;
            end else if (exp_q.size() == 0) begin
                check("idle_valid", bus.OUT_VALID, 1'b0);
            end else if (bus.OUT_VALID) begin
                w = exp_q[0];
                check("out_index", bus.OUT_INDEX, w.idx);
                check("out_data", bus.OUT_DATA, w.data);
                check("out_last", bus.OUT_LAST, w.last);
                check("rd_addr", bus.RD_ADDR, (w.idx + 1) % NUM);
                if (bus.OUT_READY) begin
                    void'(exp_q.pop_front());
                    a.idx  = int'(bus.OUT_INDEX);
                    a.data = bus.OUT_DATA;
                    a.last = bus.OUT_LAST;
                    acc_q.push_back(a);
                    if (w.last) exp_done_next = 1'b1;
                end
            end
        end
    end

    // One dump. mode: 0 ready high, 1 ready toggling, 2 random ready, 3 ready low until cycle 5.
    task automatic run_dump(input int first, input int last, input int mode, input int abort_at,
                            input bit spurious, input bit check_lat);
        int start_done  = done_cnt;
        int after_abort = -1;
        bit finished    = 1'b0;
        acc_q.delete();
        @(posedge clk); #1;
        bus.START     = 1'b1;
        bus.FIRST_REG = AW'(first);
        bus.LAST_REG  = AW'(last);
        bus.ABORT     = (abort_at == 0);
        bus.OUT_READY = 1'b0;
        if (abort_at == 0) after_abort = 0;
        push_dump(first, last);
        just_started = 1'b1;
        for (int cyc = 1; cyc < 400; cyc++) begin
            @(posedge clk); #1;
            if (check_lat && cyc == 1) check("latency_c1_valid", bus.OUT_VALID, 1'b0);
            if (check_lat && cyc == 2) check("latency_c2_valid", bus.OUT_VALID, 1'b1);
            bus.START = 1'b0;
            bus.ABORT = 1'b0;
            if (done_cnt != start_done || (after_abort >= 0 && cyc - after_abort >= 3)) begin
                finished = 1'b1;
                break;
            end
            case (mode)
                0:       bus.OUT_READY = 1'b1;
                1:       bus.OUT_READY = (cyc % 2 == 0);
                2:       bus.OUT_READY = ($urandom_range(0, 3) != 0);
                default: bus.OUT_READY = (cyc >= 5);
            endcase
            if (cyc == abort_at && exp_q.size() > 0) begin
                bus.ABORT     = 1'b1;
                bus.OUT_READY = 1'b0;
                after_abort   = cyc;
            end else if (spurious && exp_q.size() > 0 && $urandom_range(0, 2) == 0) begin
                bus.START     = 1'b1;
                bus.FIRST_REG = AW'($urandom);
                bus.LAST_REG  = AW'($urandom);
            end
        end
        check("dump_finished", finished, 1'b1);
        if (after_abort >= 0) check("abort_no_done", done_cnt - start_done, 0);
        else                  check("done_pulses", done_cnt - start_done, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int first;
        int last;
        int exp_wrap [4] = '{30, 31, 0, 1};
        bus.START     = 1'b0;
        bus.ABORT     = 1'b0;
        bus.FIRST_REG = '0;
        bus.LAST_REG  = '0;
        bus.OUT_READY = 1'b0;
        for (int i = 0; i < NUM; i++) regs[i] = DW'(i) * 32'h0101;

        // Reset state.
        repeat (2) @(posedge clk);
        #2;
        check("rst_rd_addr", bus.RD_ADDR, 0);
        check("rst_valid", bus.OUT_VALID, 0);
        check("rst_data", bus.OUT_DATA, 0);
        check("rst_index", bus.OUT_INDEX, 0);
        check("rst_last", bus.OUT_LAST, 0);
        check("rst_busy", bus.BUSY, 0);
        check("rst_done", bus.DONE, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Full range, sink always ready.
        run_dump(0, 31, 0, -1, 1'b0, 1'b1);
        check("full_count", acc_q.size(), 32);
        if (acc_q.size() == 32) begin
            check("full_first_data", acc_q[0].data, 32'h0000);
            check("full_last_idx", acc_q[31].idx, 31);
            check("full_last_data", acc_q[31].data, 32'h1F1F);
            check("full_last_flag", acc_q[31].last, 1'b1);
            check("full_prev_flag", acc_q[30].last, 1'b0);
        end

        // Wrapped range.
        run_dump(30, 1, 0, -1, 1'b0, 1'b0);
        check("wrap_count", acc_q.size(), 4);
        for (int k = 0; k < 4 && k < acc_q.size(); k++) check("wrap_idx", acc_q[k].idx, exp_wrap[k]);
        if (acc_q.size() == 4) check("wrap_last", acc_q[3].last, 1'b1);

        // Single word held through a three-cycle stall.
        run_dump(5, 5, 3, -1, 1'b0, 1'b0);
        check("single_count", acc_q.size(), 1);
        if (acc_q.size() == 1) begin
            check("single_data", acc_q[0].data, 32'h0505);
            check("single_last", acc_q[0].last, 1'b1);
        end

        // Toggling ready.
        run_dump(0, 7, 1, -1, 1'b0, 1'b0);
        check("toggle_count", acc_q.size(), 8);
        for (int k = 0; k < acc_q.size(); k++) check("toggle_idx", acc_q[k].idx, k);

        // Start and abort together in idle.
        run_dump(0, 3, 0, 0, 1'b0, 1'b0);
        check("start_abort_count", acc_q.size(), 0);

        // Abort mid-dump, then a clean dump.
        run_dump(0, 31, 0, 4, 1'b0, 1'b0);
        check("abort_count", acc_q.size(), 2);
        run_dump(0, 3, 0, -1, 1'b0, 1'b0);
        check("after_abort_count", acc_q.size(), 4);

        // Start pulses while busy are ignored.
        run_dump(2, 9, 0, -1, 1'b1, 1'b0);
        check("busy_start_count", acc_q.size(), 8);
        for (int k = 0; k < acc_q.size(); k++) check("busy_start_idx", acc_q[k].idx, k + 2);

        // Asynchronous reset mid-dump.
        @(posedge clk); #1;
        bus.START     = 1'b1;
        bus.FIRST_REG = AW'(0);
        bus.LAST_REG  = AW'(31);
        bus.OUT_READY = 1'b1;
        push_dump(0, 31);
        just_started = 1'b1;
        @(posedge clk); #1;
        bus.START = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("pre_reset_valid", bus.OUT_VALID, 1'b1);
        rst = 1'b0;
        #1;
        check("arst_rd_addr", bus.RD_ADDR, 0);
        check("arst_valid", bus.OUT_VALID, 0);
        check("arst_data", bus.OUT_DATA, 0);
        check("arst_index", bus.OUT_INDEX, 0);
        check("arst_last", bus.OUT_LAST, 0);
        check("arst_busy", bus.BUSY, 0);
        check("arst_done", bus.DONE, 0);
        @(posedge clk); #2;
        rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("post_reset_valid", bus.OUT_VALID, 1'b0);
        check("post_reset_busy", bus.BUSY, 1'b0);

        // Randomized dumps with random stalls, occasional aborts and stray starts.
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < NUM; i++) regs[i] = $urandom;
            first = $urandom_range(0, NUM - 1);
            last  = $urandom_range(0, NUM - 1);
            n     = ((last - first + NUM) % NUM) + 1;
            if ($urandom_range(0, 4) == 0) begin
                run_dump(first, last, 2, $urandom_range(1, 30), 1'b1, 1'b0);
            end else begin
                run_dump(first, last, $urandom_range(0, 1) * 2, -1, 1'b1, 1'b0);
                check("rand_count", acc_q.size(), n);
            end
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_dump_reader.md
REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register word width.
REQ-002 SHALL have parameter REG_ADD_WIDTH, default 5, register address width.
REQ-003 SHALL have parameter NUM_REGS, default 2**REG_ADD_WIDTH, register count.
REQ-004 SHALL have port CLK  input  1  clock; all state changes on rising edge.
REQ-005 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port START  input  1  begin dump; sampled in IDLE only.
REQ-007 SHALL have port ABORT  input  1  cancel dump in progress.
REQ-008 SHALL have port FIRST_REG  input  REG_ADD_WIDTH  first address; sampled with START.
REQ-009 SHALL have port LAST_REG  input  REG_ADD_WIDTH  last address, inclusive; sampled with START.
REQ-010 SHALL have port RD_ADDR  output  REG_ADD_WIDTH  register-file read-port address.
REQ-011 SHALL have port RD_DATA  input  DATA_WIDTH  register-file read data, combinational from RD_ADDR.
REQ-012 SHALL have port OUT_VALID  output  1  output word valid.
REQ-013 SHALL have port OUT_READY  input  1  sink accepts word.
REQ-014 SHALL have port OUT_DATA  output  DATA_WIDTH  captured register value.
REQ-015 SHALL have port OUT_INDEX  output  REG_ADD_WIDTH  address OUT_DATA was read from.
REQ-016 SHALL have port OUT_LAST  output  1  marks final word of dump.
REQ-017 SHALL have port BUSY  output  1  high in STREAM and DRAIN.
REQ-018 SHALL have port DONE  output  1  one-cycle pulse on normal completion.

Function
REQ-019 SHALL implement states IDLE, STREAM, DRAIN, FIN.
REQ-020 IDLE: START=1 and ABORT=0 -> STREAM; latch FIRST_REG into address counter, word count = ((LAST_REG-FIRST_REG) mod NUM_REGS)+1.
REQ-021 RD_ADDR SHALL be the address counter register output, never combinational from inputs.
REQ-022 Load condition: state STREAM and (OUT_VALID=0 or OUT_READY=1); on load, OUT_DATA<=RD_DATA, OUT_INDEX<=RD_ADDR, OUT_VALID<=1, OUT_LAST<=(remaining count==1), counter increments, remaining count decrements.
REQ-023 Address counter SHALL wrap NUM_REGS-1 -> 0; FIRST_REG>LAST_REG dumps wrapped range (e.g. 30,31,0,1).
REQ-024 FIRST_REG==LAST_REG SHALL dump exactly one word; full range (FIRST=0, LAST=NUM_REGS-1) dumps NUM_REGS words.
REQ-025 Throughput SHALL be one word per cycle while OUT_READY=1; first OUT_VALID two cycles after START sampled.
REQ-026 OUT_VALID=1 and OUT_READY=0 SHALL hold OUT_DATA, OUT_INDEX, OUT_LAST and RD_ADDR stable.
REQ-027 After the load of the last word, STREAM -> DRAIN; OUT_VALID with OUT_READY in DRAIN -> FIN, OUT_VALID<=0, OUT_LAST<=0.
REQ-028 FIN SHALL last one cycle with DONE=1, then -> IDLE.
REQ-029 START while BUSY or in FIN SHALL be ignored.
REQ-030 ABORT=1 in STREAM or DRAIN SHALL go to IDLE next edge, clear OUT_VALID and OUT_LAST, no DONE pulse; ABORT wins over same-cycle load.
REQ-031 START and ABORT together in IDLE SHALL leave the block in IDLE.
REQ-032 Data SHALL reflect RD_DATA in the cycle of its load; concurrent register writes are not snapshotted.

Reset
REQ-033 RST=0 SHALL asynchronously force IDLE, RD_ADDR=0, OUT_VALID=0, OUT_DATA=0, OUT_INDEX=0, OUT_LAST=0, BUSY=0, DONE=0, counters=0.
REQ-034 Reset asserted mid-dump SHALL discard the dump; after release no output until a new START.

Verification
REQ-035 Regs preloaded reg[i]=i*16'h0101; START, FIRST=0, LAST=31, OUT_READY=1 -> 32 words back-to-back, index 0..31, OUT_LAST only on index 31, DONE pulse one cycle later.
REQ-036 FIRST=30, LAST=1, OUT_READY=1 -> indices 30,31,0,1, OUT_LAST on index 1, one DONE.
REQ-037 FIRST=LAST=5, OUT_READY low 3 cycles then high -> single word reg[5] held stable 3 cycles, OUT_LAST=1, DONE after acceptance.
REQ-038 FIRST=0, LAST=7, OUT_READY toggling 1,0,1,0 -> 8 words in order, no duplicates or drops, stable during stalls.
REQ-039 ABORT on 4th cycle of full dump -> OUT_VALID=0 and BUSY=0 next cycle, DONE never asserted; subsequent START runs cleanly.
REQ-040 RST=0 mid-dump with OUT_VALID=1 -> all outputs 0 immediately without clock edge; START during BUSY ignored (no restart of index).
